// File: rtl/udma_pkg.sv
// udma_pkg : shared uDMA channel types and helpers
// rev 1.0
`default_nettype none

package udma_pkg;

  localparam int UDMA_L2_AWIDTH_NOAL = 21;
  localparam int UDMA_TRANS_SIZE     = 20;

  typedef logic [UDMA_L2_AWIDTH_NOAL-1:0] ch_addr_t;
  typedef logic [UDMA_TRANS_SIZE-1:0]     ch_trans_t;
  typedef logic [UDMA_TRANS_SIZE-1:0]     ch_stride_t;
  typedef logic [UDMA_TRANS_SIZE-1:0]     ch_rowlen_t;

  typedef enum logic [0:0] {
    ADDRGEN_IDLE = 1'b0,
    ADDRGEN_RUN  = 1'b1
  } addrgen_state_e;

  typedef struct packed {
    ch_addr_t   startaddr;
    ch_trans_t  size;
    ch_rowlen_t row_len;
    ch_stride_t stride;
    logic       mode_2d;
    logic       continuous;
    logic [1:0] datasize;
  } udma_addrgen_cfg_t;

  // Datasize 3 is a word, like datasize 2.
  function automatic logic [1:0] addrgen_shift(input logic [1:0] datasize);
    return (datasize == 2'd3) ? 2'd2 : datasize;
  endfunction

endpackage

`default_nettype wire

// File: rtl/udma_ch_cfg_shadow.sv
// udma_ch_cfg_shadow : single-entry holding register for the queued transfer config
// rev 1.0
`default_nettype none

module udma_ch_cfg_shadow
  import udma_pkg::*;
(
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              set_i,
  input  logic              consume_i,
  input  logic              clr_i,
  input  udma_addrgen_cfg_t cfg_i,
  output logic              valid_o,
  output udma_addrgen_cfg_t cfg_o
);

  logic              valid_q, valid_d;
  udma_addrgen_cfg_t cfg_q, cfg_d;

  // A set in the consume cycle was already forwarded by the parent, so consume wins.
  always_comb begin
    valid_d = valid_q;
    cfg_d   = cfg_q;
    if (clr_i || consume_i) begin
      valid_d = 1'b0;
    end else if (set_i) begin
      valid_d = 1'b1;
      cfg_d   = cfg_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_q <= 1'b0;
      cfg_q   <= '0;
    end else begin
      valid_q <= valid_d;
      cfg_q   <= cfg_d;
    end
  end

  assign valid_o = valid_q;
  assign cfg_o   = cfg_q;

endmodule

`default_nettype wire

// File: rtl/udma_ch_addrgen_2d.sv
// udma_ch_addrgen_2d : linear/2D beat address generator for one uDMA channel
// rev 1.0
`default_nettype none

module udma_ch_addrgen_2d
  import udma_pkg::*;
#(
  parameter int L2_AWIDTH_NOAL = UDMA_L2_AWIDTH_NOAL,
  parameter int TRANS_SIZE     = UDMA_TRANS_SIZE
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_startaddr_i,
  input  logic [TRANS_SIZE-1:0]     cfg_size_i,
  input  logic [TRANS_SIZE-1:0]     cfg_row_len_i,
  input  logic [TRANS_SIZE-1:0]     cfg_stride_i,
  input  logic                      cfg_mode_2d_i,
  input  logic                      cfg_continuous_i,
  input  logic [1:0]                cfg_datasize_i,
  input  logic                      cfg_en_i,
  input  logic                      cfg_clr_i,
  input  logic                      int_not_stall_i,
  output logic                      int_en_o,
  output logic                      int_pending_o,
  output logic [L2_AWIDTH_NOAL-1:0] int_addr_o,
  output logic [1:0]                int_datasize_o,
  output logic [TRANS_SIZE-1:0]     int_bytes_left_o,
  output logic                      evt_row_o,
  output logic                      evt_eot_o
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]                state_q, state_d;
  logic [L2_AWIDTH_NOAL-1:0] addr_q, addr_d;
  logic [L2_AWIDTH_NOAL-1:0] row_start_q, row_start_d;
  logic [TRANS_SIZE-1:0]     bytes_left_q, bytes_left_d;
  logic [TRANS_SIZE-1:0]     row_cnt_q, row_cnt_d;
  udma_addrgen_cfg_t         act_q, act_d;
  logic                      evt_row_q, evt_row_d;
  logic                      evt_eot_q, evt_eot_d;

  udma_addrgen_cfg_t         cfg_in, shadow_cfg, load_cfg;
  logic                      shadow_valid, shadow_set, shadow_consume, do_load;
  logic                      start_req, is_2d, last_beat, row_done;
  logic [TRANS_SIZE-1:0]     incr, row_len;
  logic [L2_AWIDTH_NOAL-1:0] incr_a, stride_a;

  assign cfg_in = '{
    startaddr:  UDMA_L2_AWIDTH_NOAL'(cfg_startaddr_i),
    size:       UDMA_TRANS_SIZE'(cfg_size_i),
    row_len:    UDMA_TRANS_SIZE'(cfg_row_len_i),
    stride:     UDMA_TRANS_SIZE'(cfg_stride_i),
    mode_2d:    cfg_mode_2d_i,
    continuous: cfg_continuous_i,
    datasize:   cfg_datasize_i
  };

  assign start_req = cfg_en_i && (cfg_size_i != '0);
  assign incr      = TRANS_SIZE'(1) << addrgen_shift(act_q.datasize);
  assign incr_a    = L2_AWIDTH_NOAL'(incr);
  assign row_len   = TRANS_SIZE'(act_q.row_len);
  assign stride_a  = L2_AWIDTH_NOAL'(act_q.stride);
  assign is_2d     = act_q.mode_2d && (row_len != '0);
  assign last_beat = bytes_left_q <= incr;
  // One extra bit so a row count near the top of the range cannot wrap.
  assign row_done  = ({1'b0, row_cnt_q} + {1'b0, incr}) >= {1'b0, row_len};

  udma_ch_cfg_shadow u_shadow (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .set_i     (shadow_set),
    .consume_i (shadow_consume),
    .clr_i     (cfg_clr_i),
    .cfg_i     (cfg_in),
    .valid_o   (shadow_valid),
    .cfg_o     (shadow_cfg)
  );

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    row_start_d    = row_start_q;
    bytes_left_d   = bytes_left_q;
    row_cnt_d      = row_cnt_q;
    act_d          = act_q;
    evt_row_d      = 1'b0;
    evt_eot_d      = 1'b0;
    shadow_set     = 1'b0;
    shadow_consume = 1'b0;
    do_load        = 1'b0;
    load_cfg       = cfg_in;

    if (cfg_clr_i) begin
      state_d      = S_IDLE;
      bytes_left_d = '0;
      row_cnt_d    = '0;
    end else if (state_q == S_IDLE) begin
      do_load = start_req;
    end else begin
      shadow_set = start_req;
      if (int_not_stall_i) begin
        if (last_beat) begin
          evt_eot_d    = 1'b1;
          evt_row_d    = is_2d;
          bytes_left_d = '0;
          // A start arriving with the last beat bypasses the shadow directly.
          if (start_req) begin
            do_load        = 1'b1;
            shadow_consume = 1'b1;
          end else if (shadow_valid) begin
            do_load        = 1'b1;
            load_cfg       = shadow_cfg;
            shadow_consume = 1'b1;
          end else if (act_q.continuous) begin
            do_load  = 1'b1;
            load_cfg = act_q;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          bytes_left_d = bytes_left_q - incr;
          if (is_2d && row_done) begin
            addr_d      = row_start_q + stride_a;
            row_start_d = row_start_q + stride_a;
            row_cnt_d   = '0;
            evt_row_d   = 1'b1;
          end else begin
            addr_d = addr_q + incr_a;
            if (is_2d) begin
              row_cnt_d = row_cnt_q + incr;
            end
          end
        end
      end
    end

    if (do_load) begin
      state_d      = S_RUN;
      act_d        = load_cfg;
      addr_d       = L2_AWIDTH_NOAL'(load_cfg.startaddr);
      row_start_d  = L2_AWIDTH_NOAL'(load_cfg.startaddr);
      bytes_left_d = TRANS_SIZE'(load_cfg.size);
      row_cnt_d    = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      row_start_q  <= '0;
      bytes_left_q <= '0;
      row_cnt_q    <= '0;
      act_q        <= '0;
      evt_row_q    <= 1'b0;
      evt_eot_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      row_start_q  <= row_start_d;
      bytes_left_q <= bytes_left_d;
      row_cnt_q    <= row_cnt_d;
      act_q        <= act_d;
      evt_row_q    <= evt_row_d;
      evt_eot_q    <= evt_eot_d;
    end
  end

  assign int_en_o         = (state_q == S_RUN);
  assign int_pending_o    = shadow_valid;
  assign int_addr_o       = addr_q;
  assign int_datasize_o   = act_q.datasize;
  assign int_bytes_left_o = bytes_left_q;
  assign evt_row_o        = evt_row_q;
  assign evt_eot_o        = evt_eot_q;

endmodule

`default_nettype wire

// File: tb/tb_udma_ch_addrgen_2d.sv
// tb_udma_ch_addrgen_2d : directed + random bench against a beat-index reference model
// rev 1.0
`default_nettype none

module tb_udma_ch_addrgen_2d;
  import udma_pkg::*;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic [20:0] cfg_startaddr_i;
  logic [19:0] cfg_size_i, cfg_row_len_i, cfg_stride_i;
  logic        cfg_mode_2d_i, cfg_continuous_i, cfg_en_i, cfg_clr_i, int_not_stall_i;
  logic [1:0]  cfg_datasize_i;
  logic        int_en_o, int_pending_o, evt_row_o, evt_eot_o;
  logic [20:0] int_addr_o;
  logic [1:0]  int_datasize_o;
  logic [19:0] int_bytes_left_o;

  int total = 0;
  int bad   = 0;

  // Reference model: a transfer is its config plus the index of the current beat.
  bit                m_en, m_pend, m_evr, m_eve;
  udma_addrgen_cfg_t m_cfg, m_sh;
  int                m_k;

  udma_ch_addrgen_2d dut (
    .clk_i            (clk),
    .rstn_i           (rstn_i),
    .cfg_startaddr_i  (cfg_startaddr_i),
    .cfg_size_i       (cfg_size_i),
    .cfg_row_len_i    (cfg_row_len_i),
    .cfg_stride_i     (cfg_stride_i),
    .cfg_mode_2d_i    (cfg_mode_2d_i),
    .cfg_continuous_i (cfg_continuous_i),
    .cfg_datasize_i   (cfg_datasize_i),
    .cfg_en_i         (cfg_en_i),
    .cfg_clr_i        (cfg_clr_i),
    .int_not_stall_i  (int_not_stall_i),
    .int_en_o         (int_en_o),
    .int_pending_o    (int_pending_o),
    .int_addr_o       (int_addr_o),
    .int_datasize_o   (int_datasize_o),
    .int_bytes_left_o (int_bytes_left_o),
    .evt_row_o        (evt_row_o),
    .evt_eot_o        (evt_eot_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  function automatic int f_inc(input logic [1:0] ds);
    return (ds == 2'd3) ? 4 : (1 << ds);
  endfunction

  function automatic int f_beats(input udma_addrgen_cfg_t c);
    int i = f_inc(c.datasize);
    return (int'(c.size) + i - 1) / i;
  endfunction

  function automatic int f_bpr(input udma_addrgen_cfg_t c);
    int i = f_inc(c.datasize);
    return (int'(c.row_len) + i - 1) / i;
  endfunction

  function automatic bit f_2d(input udma_addrgen_cfg_t c);
    return c.mode_2d && (c.row_len != 0);
  endfunction

  // Beat k sits in row k/bpr at column k%bpr; addresses wrap at 2^21.
  function automatic logic [20:0] f_addr(input udma_addrgen_cfg_t c, input int k);
    longint a;
    int     i = f_inc(c.datasize);
    if (f_2d(c)) begin
      int b = f_bpr(c);
      a = longint'(c.startaddr) + longint'(k / b) * longint'(c.stride) + longint'((k % b) * i);
    end else begin
      a = longint'(c.startaddr) + longint'(k * i);
    end
    return a[20:0];
  endfunction

  function automatic udma_addrgen_cfg_t mk(input logic [20:0] a, input int size, input int row,
                                           input int stride, input bit m2d, input bit cont,
                                           input logic [1:0] ds);
    udma_addrgen_cfg_t c;
    c.startaddr  = a;
    c.size       = 20'(size);
    c.row_len    = 20'(row);
    c.stride     = 20'(stride);
    c.mode_2d    = m2d;
    c.continuous = cont;
    c.datasize   = ds;
    return c;
  endfunction

  function automatic udma_addrgen_cfg_t rand_cfg();
    udma_addrgen_cfg_t c;
    c.startaddr  = 21'($urandom);
    c.size       = 20'($urandom_range(0, 40));
    c.row_len    = 20'($urandom_range(0, 12));
    c.stride     = ($urandom_range(0, 3) == 0) ? 20'($urandom) : 20'($urandom_range(0, 64));
    c.mode_2d    = 1'($urandom_range(0, 1));
    c.continuous = ($urandom_range(0, 7) == 0);
    c.datasize   = 2'($urandom_range(0, 3));
    return c;
  endfunction

  task automatic model_step(input bit en, input bit clr, input bit ns, input udma_addrgen_cfg_t c);
    m_evr = 1'b0;
    m_eve = 1'b0;
    if (clr) begin
      m_en   = 1'b0;
      m_pend = 1'b0;
    end else if (!m_en) begin
      if (en && c.size != 0) begin
        m_cfg = c;
        m_k   = 0;
        m_en  = 1'b1;
      end
    end else begin
      if (en && c.size != 0) begin
        m_sh   = c;
        m_pend = 1'b1;
      end
      if (ns) begin
        if (m_k == f_beats(m_cfg) - 1) begin
          m_eve = 1'b1;
          m_evr = f_2d(m_cfg);
          if (m_pend) begin
            m_cfg  = m_sh;
            m_pend = 1'b0;
            m_k    = 0;
          end else if (m_cfg.continuous) begin
            m_k = 0;
          end else begin
            m_en = 1'b0;
          end
        end else begin
          if (f_2d(m_cfg) && (m_k % f_bpr(m_cfg)) == f_bpr(m_cfg) - 1) m_evr = 1'b1;
          m_k++;
        end
      end
    end
  endtask

  task automatic compare_outputs();
    check_eq("en", 32'(int_en_o), 32'(m_en));
    check_eq("pending", 32'(int_pending_o), 32'(m_pend));
    check_eq("evt_row", 32'(evt_row_o), 32'(m_evr));
    check_eq("evt_eot", 32'(evt_eot_o), 32'(m_eve));
    check_eq("bytes_left", 32'(int_bytes_left_o),
             m_en ? 32'(int'(m_cfg.size) - m_k * f_inc(m_cfg.datasize)) : 32'd0);
    if (m_en) begin
      check_eq("addr", 32'(int_addr_o), 32'(f_addr(m_cfg, m_k)));
      check_eq("datasize", 32'(int_datasize_o), 32'(m_cfg.datasize));
    end
  endtask

  task automatic cyc(input bit en, input bit clr, input bit ns, input udma_addrgen_cfg_t c);
    @(negedge clk);
    compare_outputs();
    cfg_en_i         = en;
    cfg_clr_i        = clr;
    int_not_stall_i  = ns;
    cfg_startaddr_i  = c.startaddr;
    cfg_size_i       = c.size;
    cfg_row_len_i    = c.row_len;
    cfg_stride_i     = c.stride;
    cfg_mode_2d_i    = c.mode_2d;
    cfg_continuous_i = c.continuous;
    cfg_datasize_i   = c.datasize;
    model_step(en, clr, ns, c);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, rand_cfg());
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_en"}, 32'(int_en_o), 32'd0);
    check_eq({tag, "_pend"}, 32'(int_pending_o), 32'd0);
    check_eq({tag, "_addr"}, 32'(int_addr_o), 32'd0);
    check_eq({tag, "_ds"}, 32'(int_datasize_o), 32'd0);
    check_eq({tag, "_bl"}, 32'(int_bytes_left_o), 32'd0);
    check_eq({tag, "_evts"}, 32'({evt_row_o, evt_eot_o}), 32'd0);
  endtask

  task automatic model_reset();
    m_en   = 1'b0;
    m_pend = 1'b0;
    m_evr  = 1'b0;
    m_eve  = 1'b0;
    m_k    = 0;
    m_cfg  = '0;
    m_sh   = '0;
  endtask

  initial begin
    rstn_i           = 1'b0;
    cfg_en_i         = 1'b0;
    cfg_clr_i        = 1'b0;
    int_not_stall_i  = 1'b0;
    cfg_startaddr_i  = '0;
    cfg_size_i       = '0;
    cfg_row_len_i    = '0;
    cfg_stride_i     = '0;
    cfg_mode_2d_i    = 1'b0;
    cfg_continuous_i = 1'b0;
    cfg_datasize_i   = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rstn_i = 1'b1;

    // Linear word transfer.
    cyc(1'b1, 1'b0, 1'b1, mk(21'h100, 12, 0, 0, 1'b0, 1'b0, 2'd2));
    idle(6);
    // 2D byte transfer, two rows.
    cyc(1'b1, 1'b0, 1'b1, mk(21'h0, 8, 4, 'h20, 1'b1, 1'b0, 2'd0));
    idle(11);
    // Queued second transfer.
    cyc(1'b1, 1'b0, 1'b1, mk(21'h200, 8, 0, 0, 1'b0, 1'b0, 2'd2));
    cyc(1'b1, 1'b0, 1'b1, mk(21'h400, 4, 0, 0, 1'b0, 1'b0, 2'd2));
    idle(5);
    // Continuous, then clear.
    cyc(1'b1, 1'b0, 1'b1, mk(21'h300, 4, 0, 0, 1'b0, 1'b1, 2'd2));
    idle(5);
    cyc(1'b0, 1'b1, 1'b1, rand_cfg());
    idle(3);
    // Clear with enable while running, then a zero-size start.
    cyc(1'b1, 1'b0, 1'b1, mk(21'h500, 40, 0, 0, 1'b0, 1'b0, 2'd2));
    idle(2);
    cyc(1'b1, 1'b1, 1'b1, mk(21'h600, 8, 0, 0, 1'b0, 1'b0, 2'd2));
    idle(2);
    cyc(1'b1, 1'b0, 1'b1, mk(21'h10, 0, 0, 0, 1'b0, 1'b0, 2'd2));
    idle(2);
    // Address wrap with a size that is not a multiple of the beat.
    cyc(1'b1, 1'b0, 1'b1, mk(21'h1FFFFC, 6, 0, 0, 1'b0, 1'b0, 2'd2));
    idle(4);
    // Asynchronous reset in the middle of a transfer.
    cyc(1'b1, 1'b0, 1'b1, mk(21'h700, 40, 8, 'h100, 1'b1, 1'b0, 2'd1));
    idle(3);
    cfg_en_i = 1'b0;
    #2 rstn_i = 1'b0;
    #1 check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    rstn_i = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 3) != 0), rand_cfg());
    end
    @(negedge clk);
    compare_outputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/udma_ch_addrgen_2d.md
Name: udma_ch_addrgen_2d

Overview:
- Parametrised address generator for one uDMA linear channel; the next generation of the fixed 1D TX/RX channel bookkeeping.
- Adds a 2D (row length + stride) mode, a queued ("pending") second transfer, continuous re-arm, and per-row and end-of-transfer events.
- Sits between the channel cfg registers and the uDMA core arbiter; produces the L2 byte address, datasize and bytes-left for every beat.

Parameters:
- L2_AWIDTH_NOAL, 21, byte-address width into L2.
- TRANS_SIZE, 20, width of size, row-length, stride and bytes-left counters.

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  asynchronous active-low reset
- cfg_startaddr_i  in  L2_AWIDTH_NOAL  transfer start byte address
- cfg_size_i  in  TRANS_SIZE  total bytes
- cfg_row_len_i  in  TRANS_SIZE  bytes per row (2D)
- cfg_stride_i  in  TRANS_SIZE  row-start to row-start distance in bytes (2D)
- cfg_mode_2d_i  in  1  1 = 2D, 0 = linear
- cfg_continuous_i  in  1  re-arm at end of transfer
- cfg_datasize_i  in  2  0 = byte, 1 = half, 2 = word, 3 = word
- cfg_en_i  in  1  start pulse
- cfg_clr_i  in  1  abort pulse
- int_not_stall_i  in  1  current beat consumed this cycle
- int_en_o  out  1  transfer active
- int_pending_o  out  1  second transfer queued
- int_addr_o  out  L2_AWIDTH_NOAL  address of current beat
- int_datasize_o  out  2  datasize of current transfer
- int_bytes_left_o  out  TRANS_SIZE  bytes remaining incl. current beat
- evt_row_o  out  1  one-cycle pulse, row finished (2D only)
- evt_eot_o  out  1  one-cycle pulse, transfer finished

Behaviour:
- Reset (async, rstn_i low): all outputs and internal state 0; FSM in IDLE.
- FSM states: IDLE and RUN.
- Increment incr = 1 << min(datasize, 2).
- Configuration handling:
  - Active config (addr, size, row_len, stride, mode, datasize, continuous) is latched at start.
  - 2D with row_len = 0 behaves as linear.
- IDLE + cfg_en_i with cfg_size_i != 0:
  - Latch config.
  - addr = startaddr, bytes_left = size, row_start = startaddr, row_cnt = 0.
  - Go to RUN; int_en_o = 1 from the next cycle.
  - cfg_size_i = 0: ignored, no event.
- RUN: a beat advances only on int_not_stall_i. No advance means all outputs hold.
- Beat, not last:
  - bytes_left -= incr.
  - Linear: addr += incr.
  - 2D: if row_cnt + incr >= row_len, then addr = row_start + stride, row_start += stride, row_cnt = 0, evt_row_o pulses next cycle. Otherwise addr += incr, row_cnt += incr.
- Last beat (bytes_left <= incr):
  - evt_eot_o pulses next cycle.
  - evt_row_o also pulses if in 2D mode.
  - Then:
    - pending set: load the shadow config, clear pending, stay RUN, int_en_o stays 1 with no bubble.
    - else continuous: reload the active config, stay RUN.
    - else: IDLE, int_en_o = 0, bytes_left = 0.
- cfg_en_i in RUN (size != 0):
  - Capture the cfg inputs into the shadow register and set int_pending_o.
  - A further cfg_en_i while pending overwrites the shadow; only one entry is queued.
- Same cycle as last beat: a cfg_en_i is captured into pending first, then consumed by the EOT reload in that same cycle, so pending ends 0 and the new config runs.
- cfg_clr_i (synchronous, highest priority):
  - FSM to IDLE; pending, bytes_left, row_cnt, int_en_o set to 0; no evt_eot_o.
  - clr + en in the same cycle: clr wins, en dropped.
- Arithmetic:
  - Address arithmetic is modulo 2^L2_AWIDTH_NOAL (silent wrap).
  - bytes_left never underflows; the last beat sets it to 0 when size is not a multiple of incr.
  - Stride is zero-extended to the address width.
- Registering: int_addr_o, int_bytes_left_o and the events are registered, so cfg-to-output latency is 1 cycle.
- Reset mid-transfer: immediate return to reset values; no events.

Decomposition:
- Add to udma_pkg:
  - ch_stride_t and ch_rowlen_t (TRANS_SIZE wide).
  - addrgen_state_e {IDLE, RUN}.
  - Packed struct udma_addrgen_cfg_t {startaddr, size, row_len, stride, mode_2d, continuous, datasize}.
- One sub-module, udma_ch_cfg_shadow: the pending config holding register with set, consume and clear. All counters stay in the top module.

Test Plan:
- Linear word transfer: start = 0x100, size = 12, datasize = 2, stall low → addr 0x100, 0x104, 0x108; bytes_left 12, 8, 4; evt_eot_o one cycle after the third beat; int_en_o = 0 after.
- 2D byte transfer: start = 0x0, size = 8, row_len = 4, stride = 0x20 → addr 0x0–0x3 then 0x20–0x23; evt_row_o twice; evt_eot_o once.
- Pending: start A (0x200, size 8, word); mid-transfer start B (0x400, size 4) → int_pending_o = 1; A's beats at 0x200, 0x204, then 0x400 with no idle cycle; two evt_eot_o.
- Continuous: size = 4, word, continuous = 1, free-running for 3 EOTs → addr repeats 0x300; evt_eot_o every 1 beat; cfg_clr_i then stops with no EOT.
- Clear vs. enable: cfg_clr_i and cfg_en_i in the same cycle while RUN → IDLE, pending 0, no EOT; size = 0 start → stays IDLE.
- Wrap and odd sizes: start = 0x1FFFFC, size = 6, word → addr 0x1FFFFC then 0x000000; bytes_left 6, 2, then 0 with EOT.
